// File: rtl/datapath_pipe_pkg.sv
// Shared opcodes and stage bundles for the pipelined datapath.
// EX bundle fields are sized for the widest supported configuration.
package dp_pkg;

  localparam int DP_MAX_DBITS = 64;
  localparam int DP_MAX_ABITS = 10;

  localparam logic [5:0] ALU_ADDU = 6'b000001;
  localparam logic [5:0] ALU_SUBU = 6'b010001;
  localparam logic [5:0] ALU_AND  = 6'b000100;
  localparam logic [5:0] ALU_OR   = 6'b000101;
  localparam logic [5:0] ALU_XOR  = 6'b000110;
  localparam logic [5:0] ALU_NOR  = 6'b000111;
  localparam logic [5:0] ALU_SLT  = 6'b011011;
  localparam logic [5:0] ALU_SLTU = 6'b011101;
  localparam logic [5:0] ALU_SLL  = 6'b001000;
  localparam logic [5:0] ALU_SRL  = 6'b001001;
  localparam logic [5:0] ALU_SRA  = 6'b001011;
  localparam logic [5:0] ALU_MULU = 6'b011001;

  typedef struct packed {
    logic                    valid;
    logic [DP_MAX_DBITS-1:0] A;
    logic [DP_MAX_DBITS-1:0] B;
    logic [5:0]              ALUFN;
    logic [DP_MAX_ABITS-1:0] WriteAddr;
  } ex_stage_t;

endpackage

// File: rtl/datapath_pipe_if.sv
// Issue handshake, host write port and WB result bus.
// master drives operations, slave is the datapath.
interface datapath_pipe_if
  import dp_pkg::*;
#(
  parameter int Nloc  = 32,
  parameter int Dbits = 32
);
  localparam int Abits = $clog2(Nloc);

  logic             in_valid;
  logic             in_ready;
  logic [Abits-1:0] ReadAddr1;
  logic [Abits-1:0] ReadAddr2;
  logic [Abits-1:0] WriteAddr;
  logic [5:0]       ALUFN;
  logic             HostWE;
  logic [Abits-1:0] HostWA;
  logic [Dbits-1:0] HostWD;
  logic             out_valid;
  logic [Abits-1:0] out_WriteAddr;
  logic [Dbits-1:0] ALUResult;
  logic             FlagZ;

  modport master (
    output in_valid, ReadAddr1, ReadAddr2,
    output WriteAddr, ALUFN,
    output HostWE, HostWA, HostWD,
    input  in_ready, out_valid,
    input  out_WriteAddr, ALUResult, FlagZ
  );

  modport slave (
    input  in_valid, ReadAddr1, ReadAddr2,
    input  WriteAddr, ALUFN,
    input  HostWE, HostWA, HostWD,
    output in_ready, out_valid,
    output out_WriteAddr, ALUResult, FlagZ
  );

endinterface

// File: rtl/datapath_pipe_alu_comb.sv
// Combinational ALU, every op except MULU.
// Unknown opcodes (MULU included) give 0.
module alu_comb
  import dp_pkg::*;
#(
  parameter int Dbits = 32
) (
  input  logic [Dbits-1:0] i_a,
  input  logic [Dbits-1:0] i_b,
  input  logic [5:0]       i_alufn,
  output logic [Dbits-1:0] o_y
);
  localparam int Sbits = $clog2(Dbits);

  logic [Sbits-1:0] w_sh;
  logic             w_slt;
  logic             w_sltu;

  assign w_sh   = i_a[Sbits-1:0];
  assign w_slt  = $signed(i_a) < $signed(i_b);
  assign w_sltu = i_a < i_b;

  // opcode decode
  always_comb begin
    o_y = '0;
    case (i_alufn)
      ALU_ADDU: o_y = i_a + i_b;
      ALU_SUBU: o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_NOR:  o_y = ~(i_a | i_b);
      ALU_SLT:  o_y = {{(Dbits-1){1'b0}}, w_slt};
      ALU_SLTU: o_y = {{(Dbits-1){1'b0}}, w_sltu};
      ALU_SLL:  o_y = i_b << w_sh;
      ALU_SRL:  o_y = i_b >> w_sh;
      ALU_SRA:  o_y = $signed(i_b) >>> w_sh;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Accept -> EX -> WB datapath with forwarding,
// iterative MULU that stalls issue, and host write port.
module datapath_pipe
  import dp_pkg::*;
#(
  parameter int Nloc    = 32,
  parameter int Dbits   = 32,
  parameter int ZeroReg = 1
) (
  input logic clock,
  input logic reset,
  datapath_pipe_if.slave bus
);
  localparam int Abits = $clog2(Nloc);
  localparam int Cbits = $clog2(Dbits);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [Dbits-1:0] r_rf [Nloc];
  ex_stage_t        r_ex;
  ex_stage_t        w_ex_next;
  logic [0:0]       r_state;
  logic [Cbits-1:0] r_cnt;
  logic [Dbits-1:0] r_acc;
  logic [Dbits-1:0] r_mc;
  logic [Dbits-1:0] r_mp;
  logic             r_wb_valid;
  logic [Abits-1:0] r_wb_addr;
  logic [Dbits-1:0] r_wb_data;
  logic             r_flagz;

  logic [Dbits-1:0] w_ex_a;
  logic [Dbits-1:0] w_ex_b;
  logic [Abits-1:0] w_ex_wa;
  logic [Dbits-1:0] w_alu_y;
  logic [Dbits-1:0] w_acc_next;
  logic [Dbits-1:0] w_opa;
  logic [Dbits-1:0] w_opb;
  logic [Dbits-1:0] w_wb_res;
  logic             w_accept;
  logic             w_mul_last;
  logic             w_wb_in;
  logic             w_zr1;
  logic             w_zr2;
  logic             w_unused;

  assign w_ex_a  = r_ex.A[Dbits-1:0];
  assign w_ex_b  = r_ex.B[Dbits-1:0];
  assign w_ex_wa = r_ex.WriteAddr[Abits-1:0];
  assign w_unused = |{r_ex.A >> Dbits,
                      r_ex.B >> Dbits,
                      r_ex.WriteAddr >> Abits};

  alu_comb #(.Dbits(Dbits)) u_alu (
    .i_a     (w_ex_a),
    .i_b     (w_ex_b),
    .i_alufn (r_ex.ALUFN),
    .o_y     (w_alu_y)
  );

  assign bus.in_ready = (r_state == S_IDLE);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_mul_last   = (r_state == S_MUL) &&
                        (r_cnt == Cbits'(Dbits-1));
  assign w_acc_next   = r_acc + (r_mp[0] ? r_mc : '0);

  assign w_zr1 = (ZeroReg != 0) && (bus.ReadAddr1 == '0);
  assign w_zr2 = (ZeroReg != 0) && (bus.ReadAddr2 == '0);

  // operand read: EX result, then WB result, then regfile
  always_comb begin
    w_opa = r_rf[bus.ReadAddr1];
    if (w_zr1)
      w_opa = '0;
    else if (r_ex.valid && w_ex_wa == bus.ReadAddr1)
      w_opa = w_alu_y;
    else if (r_wb_valid && r_wb_addr == bus.ReadAddr1)
      w_opa = r_wb_data;
    w_opb = r_rf[bus.ReadAddr2];
    if (w_zr2)
      w_opb = '0;
    else if (r_ex.valid && w_ex_wa == bus.ReadAddr2)
      w_opb = w_alu_y;
    else if (r_wb_valid && r_wb_addr == bus.ReadAddr2)
      w_opb = r_wb_data;
  end

  // next EX bundle from the accepting op
  always_comb begin
    w_ex_next = '0;
    w_ex_next.valid = w_accept;
    w_ex_next.A[Dbits-1:0] = w_opa;
    w_ex_next.B[Dbits-1:0] = w_opb;
    w_ex_next.ALUFN = bus.ALUFN;
    w_ex_next.WriteAddr[Abits-1:0] = bus.WriteAddr;
  end

  // EX register and shift-add multiplier FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ex    <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mc    <= '0;
      r_mp    <= '0;
    end else begin
      if (r_state == S_IDLE || w_mul_last)
        r_ex <= w_ex_next;
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_accept && bus.ALUFN == ALU_MULU) begin
            r_state <= S_MUL;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mc    <= w_opa;
            r_mp    <= w_opb;
          end
        end
        (r_state == S_MUL): begin
          r_acc <= w_acc_next;
          r_mc  <= r_mc << 1;
          r_mp  <= r_mp >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_wb_in  = ((r_state == S_IDLE) && r_ex.valid) ||
                    w_mul_last;
  assign w_wb_res = w_mul_last ? w_acc_next : w_alu_y;

  // WB register; bubbles keep the last result visible
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_flagz    <= 1'b1;
    end else begin
      r_wb_valid <= w_wb_in;
      if (w_wb_in) begin
        r_wb_addr <= w_ex_wa;
        r_wb_data <= w_wb_res;
        r_flagz   <= (w_wb_res == '0);
      end
    end
  end

  // register file: host write, then WB write so WB wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Nloc; i++)
        r_rf[i] <= '0;
    end else begin
      if (bus.HostWE &&
          !((ZeroReg != 0) && bus.HostWA == '0))
        r_rf[bus.HostWA] <= bus.HostWD;
      if (r_wb_valid &&
          !((ZeroReg != 0) && r_wb_addr == '0))
        r_rf[r_wb_addr] <= r_wb_data;
    end
  end

  assign bus.out_valid     = r_wb_valid;
  assign bus.out_WriteAddr = r_wb_addr;
  assign bus.ALUResult     = r_wb_data;
  assign bus.FlagZ         = r_flagz;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed plus random bench for datapath_pipe
// against an architectural (sequential) register model.
module tb_datapath_pipe;
  import dp_pkg::*;

  localparam int NL = 32;
  localparam int DB = 32;

  localparam logic [5:0] OPS [13] = '{
    ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_MULU, 6'b111111};

  typedef struct {
    int          wa;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   compares = 0;
  int   fails = 0;
  int   mul_free = 0;
  bit   mon_en = 0;
  logic [31:0] model_rf [NL];
  int   last_wb [NL];
  exp_t q [$];
  exp_t mon_e;
  logic mon_v;

  datapath_pipe_if #(.Nloc(NL), .Dbits(DB)) bus ();

  datapath_pipe #(.Nloc(NL), .Dbits(DB), .ZeroReg(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(
    input logic [5:0] op, input logic [31:0] a,
    input logic [31:0] b);
    case (op)
      ALU_ADDU: return a + b;
      ALU_SUBU: return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU: return (a < b) ? 1 : 0;
      ALU_SLL:  return b << a[4:0];
      ALU_SRL:  return b >> a[4:0];
      ALU_SRA:  return $signed(b) >>> a[4:0];
      ALU_MULU: return a * b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rd(input int a);
    return (a == 0) ? 32'd0 : model_rf[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      model_rf[i] = 0;
      last_wb[i] = -1;
    end
  endtask

  task automatic step(
    input logic v, input logic [5:0] op,
    input int ra1, input int ra2, input int wa,
    input logic hwe, input int hwa,
    input logic [31:0] hwd, output logic acc);
    logic er;
    logic [31:0] r;
    int lat;
    bus.in_valid  = v;
    bus.ALUFN     = op;
    bus.ReadAddr1 = 5'(ra1);
    bus.ReadAddr2 = 5'(ra2);
    bus.WriteAddr = 5'(wa);
    bus.HostWE    = hwe;
    bus.HostWA    = 5'(hwa);
    bus.HostWD    = hwd;
    er = (cyc >= mul_free);
    compares++;
    assert (bus.in_ready === er) else begin
      fails++;
      $error("FAIL in_ready cyc=%0d got %b exp %b",
             cyc, bus.in_ready, er);
    end
    acc = v && er;
    if (acc) begin
      r = ref_alu(op, rd(ra1), rd(ra2));
      lat = (op == ALU_MULU) ? DB + 1 : 2;
      q.push_back('{wa, r, cyc + lat});
      if (wa != 0) model_rf[wa] = r;
      last_wb[wa] = cyc + lat;
      if (op == ALU_MULU) mul_free = cyc + DB + 1;
    end
    if (hwe && hwa != 0 && last_wb[hwa] < cyc)
      model_rf[hwa] = hwd;
    @(negedge clock);
  endtask

  task automatic op(input logic [5:0] o, input int a1,
                    input int a2, input int wa);
    logic acc;
    step(1'b1, o, a1, a2, wa, 1'b0, 0, 32'd0, acc);
  endtask

  task automatic host(input int wa, input logic [31:0] d);
    logic acc;
    step(1'b0, ALU_ADDU, 0, 0, 0, 1'b1, wa, d, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      step(1'b0, ALU_ADDU, 0, 0, 0, 1'b0, 0, 32'd0, acc);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    compares++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon_v = (q.size() > 0) && (q[0].cyc == cyc);
      compares++;
      assert (bus.out_valid === mon_v) else begin
        fails++;
        $error("FAIL out_valid cyc=%0d got %b exp %b",
               cyc, bus.out_valid, mon_v);
      end
      if (mon_v) begin
        mon_e = q.pop_front();
        if (bus.out_valid === 1'b1) begin
          chk("wb_addr", 32'(bus.out_WriteAddr), mon_e.wa);
          chk("wb_data", bus.ALUResult, mon_e.d);
          chk("flagz", 32'(bus.FlagZ), 32'(mon_e.d == 0));
        end
      end
    end
  end

  initial begin
    logic acc;
    int lows;
    int guard;
    int opi;
    logic [31:0] hd;
    model_clear();
    bus.in_valid = 0;
    bus.ALUFN = ALU_ADDU;
    bus.ReadAddr1 = 0;
    bus.ReadAddr2 = 0;
    bus.WriteAddr = 0;
    bus.HostWE = 0;
    bus.HostWA = 0;
    bus.HostWD = 0;
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_res", bus.ALUResult, 0);
    chk("rst_flagz", 32'(bus.FlagZ), 1);
    chk("rst_wa", 32'(bus.out_WriteAddr), 0);
    reset = 0;
    mon_en = 1;

    host(1, 5);
    host(2, 7);
    op(ALU_ADDU, 1, 2, 3);
    idle(3);
    op(ALU_ADDU, 1, 2, 3);
    op(ALU_SUBU, 3, 1, 4);
    op(ALU_XOR, 4, 3, 5);
    idle(3);
    op(ALU_ADDU, 1, 2, 0);
    op(ALU_ADDU, 0, 0, 6);
    idle(3);
    host(8, 32'hFFFFFF00);
    host(9, 16);
    host(7, 3);
    op(ALU_SLT, 8, 9, 10);
    op(ALU_SLTU, 8, 9, 10);
    op(ALU_SRA, 7, 8, 11);
    op(ALU_SRL, 7, 8, 11);
    op(6'b111111, 1, 2, 15);
    idle(3);

    op(ALU_MULU, 1, 2, 12);
    lows = 0;
    guard = 0;
    do begin
      if (bus.in_ready === 1'b0) lows++;
      step(1'b1, ALU_ADDU, 12, 0, 13, 1'b0, 0, 0, acc);
      guard++;
    end while (!acc && guard < 100);
    chk("mul_stall", lows, DB);
    idle(3);

    op(ALU_MULU, 1, 2, 12);
    idle(9);
    mon_en = 0;
    #2 reset = 1;
    #1;
    chk("arst_ready", 32'(bus.in_ready), 1);
    chk("arst_valid", 32'(bus.out_valid), 0);
    @(negedge clock);
    reset = 0;
    q.delete();
    model_clear();
    mul_free = cyc;
    chk("arst_flagz", 32'(bus.FlagZ), 1);
    chk("arst_res", bus.ALUResult, 0);
    mon_en = 1;
    idle(40);
    op(ALU_ADDU, 12, 0, 13);
    idle(3);

    host(1, 5);
    host(2, 7);
    op(ALU_ADDU, 1, 2, 3);
    idle(1);
    host(3, 32'h55);
    idle(1);
    op(ALU_ADDU, 3, 0, 4);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      opi = $urandom_range(0, 12);
      if (opi == 11 && $urandom_range(0, 3) != 0) opi = 0;
      hd = $urandom;
      step($urandom_range(0, 3) != 0, OPS[opi],
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15), hd, acc);
    end
    idle(DB + 4);
    chk("drained", q.size(), 0);
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compares, fails);
    $finish;
  end

endmodule
